nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder that splits two `4*NIBBLES`-bit operands into nibbles and drives them one nibble per clock through a single `fadd_4` instance. The block registers the carry between nibbles and assembles the result. It is the sequencing stage directly upstream of `fadd_4`, and it consumes that stage's `sum`/`cout` outputs. Valid/ready handshakes on both sides let it sit between producer and consumer pipeline stages.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range is NIBBLES ≥ 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and carry-in are valid
- `in_ready`  out  1  block can accept a new operation
- `a`  in  W  first operand
- `b`  in  W  second operand
- `cin`  in  1  carry into nibble 0
- `out_valid`  out  1  result is valid
- `out_ready`  in  1  consumer accepts the result
- `sum`  out  W  registered result
- `cout`  out  1  carry out of the top nibble
- `overflow`  out  1  signed overflow flag; present only with `NSA_OVERFLOW_EN`

## Operation
- Internal state: operand registers A_r and B_r (W bits each), carry register, nibble index `idx` (width clog2(NIBBLES), minimum 1 bit), result register.
- FSM states and transitions:
  - IDLE → RUN on `in_valid && in_ready`. That edge captures A_r=`a`, B_r=`b`, carry=`cin`, idx=0, and clears the result register.
  - RUN, each cycle:
    - Drive `fadd_4` with A_r[4*idx+:4], B_r[4*idx+:4] and the carry register.
    - Write its `sum` into result[4*idx+:4]; load the carry register from its `cout`.
    - If idx==NIBBLES-1, go to DONE; otherwise idx increments.
  - DONE → IDLE on `out_valid && out_ready`. Result and `cout` hold stable until then.
- Outputs:
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==DONE).
  - `cout` = carry register.
  - `sum` = result register.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, unsigned, modulo 2^(W+1). No saturation.
- Inputs outside an accepting edge are ignored. `a`, `b` and `cin` may change freely during RUN/DONE.
- Handshakes:
  - No same-cycle pass-through. A new operation cannot be accepted in the cycle the result is consumed, because `in_ready` is low in DONE.
  - `out_valid` never drops without `out_ready`.

## Timing
- Reset (async assert, synchronous-release usage by integrator): state=IDLE, idx=0, carry=0, result=0.
  - Output reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0.
- Latency: accept edge E0 → RUN on edges E1..E_NIBBLES → `out_valid` high immediately after edge E_NIBBLES.
  - With NIBBLES=4, the result is visible 4 cycles after acceptance.
- Minimum occupancy is NIBBLES+2 cycles per operation: the IDLE accept cycle, NIBBLES RUN cycles, and at least one DONE cycle.
- NIBBLES=1: a single RUN cycle, then DONE.
- Reset asserted mid-RUN or in DONE: the operation is discarded immediately and outputs go to their reset values. No partial result is ever flagged valid.
- Back-pressure: DONE persists indefinitely while `out_ready`=0, and `in_ready` stays 0.

## Configuration
- `NSA_OVERFLOW_EN` defined:
  - `overflow` port exists.
  - It is registered at the final RUN edge as (A_r[W-1]==B_r[W-1]) && (sum[W-1]!=A_r[W-1]), i.e. two's-complement overflow.
  - Valid with `out_valid`, held through DONE, cleared on reset and on acceptance of a new operation.
- `NSA_OVERFLOW_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use NIBBLES=4.
1. Basic add: `a`=0x1234, `b`=0x4321, `cin`=0, `out_ready`=1 → `out_valid` 4 cycles after accept, `sum`=0x5555, `cout`=0, then `in_ready`=1 the cycle after consumption.
2. Full carry ripple: `a`=0xFFFF, `b`=0x0000, `cin`=1 → `sum`=0x0000, `cout`=1; with macro, `overflow`=0.
3. Signed overflow (macro on): `a`=0x7FFF, `b`=0x0001, `cin`=0 → `sum`=0x8000, `cout`=0, `overflow`=1. Then `a`=0x8000, `b`=0x8000 → `sum`=0x0000, `cout`=1, `overflow`=1.
4. Back-pressure: `out_ready`=0 for 10 cycles after `out_valid` → `sum`/`cout` stable, `in_ready`=0, and `in_valid` pulses are ignored. Raising `out_ready` consumes exactly one result.
5. Reset mid-operation: assert `rst_n`=0 two cycles after accepting 0xAAAA+0x5555 → `out_valid`=0, `sum`=0, `in_ready`=1. After release, 0x0001+0x0001 yields 0x0002.
6. Back-to-back: keep `in_valid`=1 with a new operand pair after each result and `out_ready`=1 → one result every 6 cycles, each matching the reference sum.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: W-bit add, one nibble per clock through a single fadd_4, valid/ready on both sides.
// Define NSA_OVERFLOW_EN to add the registered signed-overflow output.
module fadd_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef NSA_OVERFLOW_EN
  , output logic               overflow
`endif
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_r, b_r, res;
  logic          carry;
  logic [IW-1:0] idx;
  logic [3:0]    fa, fb, fs;
  logic          fc, last, accept;
  assign fa        = a_r[4*idx +: 4];
  assign fb        = b_r[4*idx +: 4];
  assign last      = idx == IW'(NIBBLES - 1);
  assign accept    = state == IDLE && in_valid;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sum       = res;
  assign cout      = carry;
  fadd_4 u_fadd (.a(fa), .b(fb), .cin(carry), .sum(fs), .cout(fc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= RUN;
          a_r   <= a;
          b_r   <= b;
          carry <= cin;
          idx   <= '0;
          res   <= '0;
        end
        RUN: begin
          res[4*idx +: 4] <= fs;
          carry           <= fc;
          state           <= last ? DONE : RUN;
          idx             <= last ? idx : idx + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef NSA_OVERFLOW_EN
  // top nibble's fresh sum bit decides the sign of the result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overflow <= 1'b0;
    else if (accept) overflow <= 1'b0;
    else if (state == RUN && last) overflow <= (a_r[W-1] == b_r[W-1]) && (fs[3] != a_r[W-1]);
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the serial adder, NIBBLES=4.
module tb_nibble_serial_adder;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0;
  logic        in_ready, out_valid, cout;
  logic [15:0] a = '0, b = '0, sum;
`ifdef NSA_OVERFLOW_EN
  logic        overflow;
`endif
  int checks = 0, errors = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef NSA_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    check("accept in_ready", 32'(in_ready), 1);
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = 16'h5a5a; cin = ~c;
  endtask

  task automatic wait_done(input string tag, input logic [16:0] exp, input logic ov);
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, 4);
    check({tag, " sum"}, 32'(sum), 32'(exp[15:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[16]));
`ifdef NSA_OVERFLOW_EN
    check({tag, " overflow"}, 32'(overflow), 32'(ov));
`else
    if (ov === 1'bx) $display("note: unknown overflow expectation in %s", tag);
`endif
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid after take"}, 32'(out_valid), 0);
    check({tag, " in_ready after take"}, 32'(in_ready), 1);
  endtask

  logic [15:0] pa [3] = '{16'h0F0F, 16'h1111, 16'hFFFF};
  logic [15:0] pb [3] = '{16'hF0F1, 16'h2222, 16'hFFFF};
  logic        pc [3] = '{1'b0, 1'b0, 1'b1};
  logic [16:0] pe [3] = '{17'h10000, 17'h03333, 17'h1FFFF};

  initial begin
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset sum", 32'(sum), 0);
    check("reset cout", 32'(cout), 0);
`ifdef NSA_OVERFLOW_EN
    check("reset overflow", 32'(overflow), 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    start(16'h1234, 16'h4321, 1'b0); wait_done("basic", 17'h05555, 1'b0); consume("basic");
    start(16'hFFFF, 16'h0000, 1'b1); wait_done("ripple", 17'h10000, 1'b0); consume("ripple");
    start(16'h7FFF, 16'h0001, 1'b0); wait_done("ovf pos", 17'h08000, 1'b1); consume("ovf pos");
    start(16'h8000, 16'h8000, 1'b0); wait_done("ovf neg", 17'h10000, 1'b1); consume("ovf neg");

    out_ready = 1'b0;
    start(16'h9876, 16'h1234, 1'b0); wait_done("bp", 17'h0AAAA, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = 16'h0101; b = 16'h0202;
      check("bp sum hold", 32'(sum), 32'h0AAAA);
      check("bp cout hold", 32'(cout), 0);
      check("bp in_ready low", 32'(in_ready), 0);
      check("bp out_valid held", 32'(out_valid), 1);
    end
    @(negedge clk); in_valid = 1'b0;
    consume("bp");
    @(posedge clk); #1;
    check("bp single take out_valid", 32'(out_valid), 0);
    check("bp single take in_ready", 32'(in_ready), 1);

    start(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst sum", 32'(sum), 0);
    check("rst cout", 32'(cout), 0);
    check("rst in_ready", 32'(in_ready), 1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    start(16'h0001, 16'h0001, 1'b0); wait_done("post rst", 17'h00002, 1'b0); consume("post rst");

    begin
      int acc = 0, got = 0, last = -1, cyc = 0;
      out_ready = 1'b1;
      while (got < 3 && cyc < 60) begin
        @(negedge clk);
        if (out_valid) begin
          check("b2b sum", 32'(sum), 32'(pe[got][15:0]));
          check("b2b cout", 32'(cout), 32'(pe[got][16]));
          if (last >= 0) check("b2b spacing", cyc - last, 6);
          last = cyc;
          got++;
        end
        if (in_ready) begin
          in_valid = acc < 3;
          if (acc < 3) begin a = pa[acc]; b = pb[acc]; cin = pc[acc]; acc++; end
        end
        cyc++;
      end
      in_valid = 1'b0;
      check("b2b results", got, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
